// File: rtl/elipse_sequencer.sv
// Sweep sequencer for the ellipse coprocessor: issues angle indices to the point datapath
// and buffers returned (x, y) pairs in a credit-protected result FIFO for software to drain.
module elipse_sequencer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  num_points,
    output logic              dp_req_valid,
    input  logic              dp_req_ready,
    output logic [IDX_W-1:0]  dp_req_idx,
    input  logic              dp_rsp_valid,
    input  logic [DATA_W-1:0] dp_rsp_x,
    input  logic [DATA_W-1:0] dp_rsp_y,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_y,
    input  logic              rd_pop,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              irq,
    output logic              err_unexpected
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   num_q, num_d;
    logic [IDX_W-1:0]   issued_q, issued_d;
    logic [IDX_W:0]     issued_inc;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW:0]        credit_use;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic               req_valid_q, req_valid_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  mem_x_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_y_q [FIFO_DEPTH];
    logic               fire, rsp_ok, abort_take, push, pop;

    always_comb begin
        fire       = req_valid_q & dp_req_ready;
        rsp_ok     = dp_rsp_valid & (outst_q != '0);
        abort_take = abort & ((state_q == S_RUN) | (state_q == S_DRAIN));
        // Responses landing in the abort cycle are already part of the flush.
        push       = rsp_ok & (state_q != S_FLUSH) & ~abort_take;
        pop        = rd_pop & (cnt_q != '0);
        outst_d    = outst_q + CW'(fire) - CW'(rsp_ok);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        credit_use = {1'b0, outst_d} + {1'b0, cnt_d};
        issued_inc = {1'b0, issued_q} + {{IDX_W{1'b0}}, 1'b1};
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        issued_d  = issued_q + IDX_W'(fire);
        done_d    = done_q;
        aborted_d = aborted_q;
        irq_d     = 1'b0;
        err_d     = err_q | (dp_rsp_valid & (outst_q == '0));
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d     = num_points;
                    issued_d  = '0;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = (num_points == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_FLUSH;
                end else if (fire && (issued_inc == {1'b0, num_q})) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_FLUSH;
                end else if (outst_d == '0) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                irq_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (outst_d == '0) begin
                    aborted_d = 1'b1;
                    irq_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Valid is registered, so credit is judged on the counts the next cycle will hold.
        req_valid_d = (state_d == S_RUN) && (credit_use < (CW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            issued_q    <= '0;
            outst_q     <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            outst_q     <= outst_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            irq_q       <= irq_d;
            err_q       <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_x_q[i] <= '0;
                mem_y_q[i] <= '0;
            end
        end else if (push) begin
            mem_x_q[wr_ptr_q] <= dp_rsp_x;
            mem_y_q[wr_ptr_q] <= dp_rsp_y;
        end
    end

    assign dp_req_valid   = req_valid_q;
    assign dp_req_idx     = issued_q;
    assign rd_valid       = (cnt_q != '0);
    assign rd_x           = mem_x_q[rd_ptr_q];
    assign rd_y           = mem_y_q[rd_ptr_q];
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign irq            = irq_q;
    assign err_unexpected = err_q;
endmodule

// File: tb/tb_elipse_sequencer.sv
// Bench for elipse_sequencer: a latency-3 datapath model feeds a scoreboard of expected
// FIFO contents; scenario tasks drive commands and check outputs at posedge+1.
module tb_elipse_sequencer;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_points = '0;
    logic        dp_req_valid;
    logic        dp_req_ready = 1'b0;
    logic [7:0]  dp_req_idx;
    logic        dp_rsp_valid = 1'b0;
    logic [15:0] dp_rsp_x = '0;
    logic [15:0] dp_rsp_y = '0;
    logic        rd_valid;
    logic [15:0] rd_x, rd_y;
    logic        rd_pop = 1'b0;
    logic        busy, done, aborted, irq, err_unexpected;

    int errors = 0;
    int checks = 0;

    bit          ready_en = 1'b0;
    bit          stray_req = 1'b0;
    bit          discard = 1'b0;
    int unsigned ncyc = 0;
    int unsigned rsp_cnt = 0;
    int unsigned exp_rd = 0;
    int unsigned pend_due[$];
    logic [7:0]  pend_idx[$];
    logic [7:0]  hs_q[$];
    int unsigned hs_t[$];
    logic [31:0] exp_q[$];
    logic [7:0]  m_idx;

    elipse_sequencer #(.DATA_W(16), .IDX_W(8), .FIFO_DEPTH(4)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
        .num_points(num_points), .dp_req_valid(dp_req_valid), .dp_req_ready(dp_req_ready),
        .dp_req_idx(dp_req_idx), .dp_rsp_valid(dp_rsp_valid), .dp_rsp_x(dp_rsp_x),
        .dp_rsp_y(dp_rsp_y), .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_pop(rd_pop),
        .busy(busy), .done(done), .aborted(aborted), .irq(irq), .err_unexpected(err_unexpected)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] fx(input logic [7:0] i);
        return {8'h40, i};
    endfunction

    function automatic logic [15:0] fy(input logic [7:0] i);
        return 16'hFFFF - ({8'h00, i} * 16'd3);
    endfunction

    // Datapath model: ready and responses change on the falling edge.
    always @(negedge clk) begin
        ncyc++;
        dp_rsp_valid = 1'b0;
        if (!rst_n) begin
            pend_due.delete();
            pend_idx.delete();
            dp_req_ready = 1'b0;
        end else begin
            if (pend_due.size() > 0 && pend_due[0] == ncyc) begin
                m_idx = pend_idx.pop_front();
                void'(pend_due.pop_front());
                dp_rsp_valid = 1'b1;
                dp_rsp_x = fx(m_idx);
                dp_rsp_y = fy(m_idx);
                rsp_cnt++;
                if (!discard) exp_q.push_back({fx(m_idx), fy(m_idx)});
            end else if (stray_req) begin
                dp_rsp_valid = 1'b1;
                dp_rsp_x = 16'hDEAD;
                dp_rsp_y = 16'hBEEF;
            end
            dp_req_ready = ready_en;
            if (dp_req_valid && ready_en) begin
                hs_q.push_back(dp_req_idx);
                hs_t.push_back(ncyc);
                pend_due.push_back(ncyc + LAT);
                pend_idx.push_back(dp_req_idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_to_idle(input string tag, output int got, output int irqs);
        int k;
        got = 0;
        irqs = 0;
        for (k = 0; k < 200 && (busy || rd_valid); k++) begin
            if (irq) irqs++;
            if (rd_valid) begin
                checks++;
                if (exp_rd >= exp_q.size()) begin
                    errors++;
                    $display("FAIL %s_fifo_extra: got x=%h y=%h, required no entry", tag, rd_x, rd_y);
                end else if ({rd_x, rd_y} !== exp_q[exp_rd]) begin
                    errors++;
                    $display("FAIL %s_fifo_data: got %h, required %h", tag, {rd_x, rd_y}, exp_q[exp_rd]);
                end
                exp_rd++;
                got++;
            end
            rd_pop = rd_valid;
            tick();
        end
        rd_pop = 1'b0;
        if (irq) irqs++;
        checks++;
        if (k >= 200) begin errors++; $display("FAIL %s_timeout: got %0d cycles, required < 200", tag, k); end
    endtask

    task automatic test_reset();
        checks++;
        if ({dp_req_valid, busy, irq, done, aborted, err_unexpected, rd_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {dp_req_valid, busy, irq, done, aborted, err_unexpected, rd_valid});
        end
        checks++;
        if ({rd_x, rd_y, dp_req_idx} !== 40'h0) begin
            errors++; $display("FAIL reset_data: got %h, required 0", {rd_x, rd_y, dp_req_idx});
        end
    endtask

    task automatic test_basic();
        int unsigned b = hs_q.size();
        int got, irqs;
        ready_en = 1'b1;
        num_points = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, required 1", busy); end
        checks++;
        if ({dp_req_valid, dp_req_idx} !== 9'h100) begin
            errors++; $display("FAIL basic_first_req: got %h, required 100", {dp_req_valid, dp_req_idx});
        end
        drain_to_idle("basic", got, irqs);
        checks++;
        if (hs_q.size() - b != 3) begin errors++; $display("FAIL basic_req_count: got %0d, required 3", hs_q.size() - b); end
        for (int i = 0; i < 3 && b + i < hs_q.size(); i++) begin
            checks++;
            if (hs_q[b+i] !== i[7:0]) begin errors++; $display("FAIL basic_idx: got %0d, required %0d", hs_q[b+i], i); end
        end
        for (int i = 1; i < 3 && b + i < hs_t.size(); i++) begin
            checks++;
            if (hs_t[b+i] != hs_t[b+i-1] + 1) begin
                errors++; $display("FAIL back_to_back: gap %0d cycles, required 1", hs_t[b+i] - hs_t[b+i-1]);
            end
        end
        checks++;
        if (got != 3) begin errors++; $display("FAIL basic_pops: got %0d, required 3", got); end
        checks++;
        if ({done, aborted} !== 2'b10) begin errors++; $display("FAIL basic_done: got %b, required 10", {done, aborted}); end
        tick();
        if (irq) irqs++;
        checks++;
        if (irqs != 1) begin errors++; $display("FAIL basic_irq: got %0d pulses, required 1", irqs); end
    endtask

    task automatic test_credit();
        int unsigned b = hs_q.size();
        int got, irqs;
        ready_en = 1'b1;
        num_points = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        checks++;
        if (hs_q.size() - b != 4) begin errors++; $display("FAIL credit_first: got %0d reqs, required 4", hs_q.size() - b); end
        checks++;
        if ({dp_req_valid, rd_valid, busy} !== 3'b011) begin
            errors++; $display("FAIL credit_stall: got %b, required 011", {dp_req_valid, rd_valid, busy});
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({rd_x, rd_y} !== exp_q[exp_rd]) begin
                errors++; $display("FAIL credit_pop_data: got %h, required %h", {rd_x, rd_y}, exp_q[exp_rd]);
            end
            exp_rd++;
            rd_pop = 1'b1;
            tick();
        end
        rd_pop = 1'b0;
        repeat (20) tick();
        checks++;
        if (hs_q.size() - b != 6) begin errors++; $display("FAIL credit_refill: got %0d reqs, required 6", hs_q.size() - b); end
        checks++;
        if (dp_req_valid !== 1'b0) begin errors++; $display("FAIL credit_refill_valid: got %b, required 0", dp_req_valid); end
        drain_to_idle("credit", got, irqs);
        checks++;
        if (got != 8 || irqs != 1 || done !== 1'b1) begin
            errors++; $display("FAIL credit_finish: got pops=%0d irqs=%0d done=%b, required 8 1 1", got, irqs, done);
        end
        for (int i = 0; i < 10 && b + i < hs_q.size(); i++) begin
            checks++;
            if (hs_q[b+i] !== i[7:0]) begin errors++; $display("FAIL credit_idx: got %0d, required %0d", hs_q[b+i], i); end
        end
    endtask

    task automatic test_ready_stall();
        int unsigned b = hs_q.size();
        int got, irqs;
        ready_en = 1'b0;
        num_points = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({dp_req_valid, dp_req_idx} !== 9'h100) begin
                errors++; $display("FAIL stall_hold: got %h, required 100", {dp_req_valid, dp_req_idx});
            end
            tick();
        end
        ready_en = 1'b1;
        tick();
        checks++;
        if (hs_q.size() - b != 1) begin errors++; $display("FAIL stall_first_ready: got %0d reqs, required 1", hs_q.size() - b); end
        checks++;
        if (dp_req_idx !== 8'd1) begin errors++; $display("FAIL stall_next_idx: got %0d, required 1", dp_req_idx); end
        drain_to_idle("stall", got, irqs);
        checks++;
        if (got != 2 || irqs != 1) begin errors++; $display("FAIL stall_finish: got pops=%0d irqs=%0d, required 2 1", got, irqs); end
    endtask

    task automatic test_abort();
        int unsigned hb;
        int k, irqs, got;
        ready_en = 1'b1;
        num_points = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (exp_q.size() - exp_rd == 2 && hs_q.size() - rsp_cnt == 2) break;
            tick();
        end
        checks++;
        if (k >= 40) begin errors++; $display("FAIL abort_setup: got timeout, required 2 held and 2 outstanding"); end
        hb = hs_q.size();
        abort = 1'b1;
        discard = 1'b1;
        tick();
        abort = 1'b0;
        irqs = 0;
        for (k = 0; k < 40 && busy; k++) begin
            if (irq) irqs++;
            tick();
        end
        if (irq) irqs++;
        tick();
        if (irq) irqs++;
        checks++;
        if (hs_q.size() != hb) begin errors++; $display("FAIL abort_no_req: got %0d new reqs, required 0", hs_q.size() - hb); end
        checks++;
        if ({busy, aborted, done, err_unexpected} !== 4'b0100) begin
            errors++; $display("FAIL abort_flags: got %b, required 0100", {busy, aborted, done, err_unexpected});
        end
        checks++;
        if (irqs != 1) begin errors++; $display("FAIL abort_irq: got %0d pulses, required 1", irqs); end
        drain_to_idle("abort", got, irqs);
        checks++;
        if (got != 2) begin errors++; $display("FAIL abort_kept: got %0d entries, required 2", got); end
        discard = 1'b0;
    endtask

    task automatic test_zero();
        int unsigned b = hs_q.size();
        num_points = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, done, aborted, irq, dp_req_valid} !== 5'b10000) begin
            errors++; $display("FAIL zero_t1: got %b, required 10000", {busy, done, aborted, irq, dp_req_valid});
        end
        tick();
        checks++;
        if ({done, irq} !== 2'b11) begin errors++; $display("FAIL zero_t2: got %b, required 11", {done, irq}); end
        tick();
        checks++;
        if ({busy, irq, done} !== 3'b001) begin errors++; $display("FAIL zero_t3: got %b, required 001", {busy, irq, done}); end
        checks++;
        if (hs_q.size() != b) begin errors++; $display("FAIL zero_reqs: got %0d, required 0", hs_q.size() - b); end
    endtask

    task automatic test_stray();
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({err_unexpected, rd_valid} !== 2'b10) begin
            errors++; $display("FAIL stray: got err/rd_valid %b, required 10", {err_unexpected, rd_valid});
        end
    endtask

    task automatic test_reset_mid_run();
        ready_en = 1'b1;
        num_points = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b, required 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        #3 rst_n = 1'b1;
        exp_rd = exp_q.size();
        tick();
        tick();
        checks++;
        if ({busy, dp_req_valid, rd_valid} !== 3'b000) begin
            errors++; $display("FAIL midrun_after: got %b, required 000", {busy, dp_req_valid, rd_valid});
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_credit();
        test_ready_stall();
        test_abort();
        test_zero();
        test_stray();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/elipse_sequencer.md
# elipse_sequencer

Sequencer between the ellipse coprocessor's AXI4-Lite register block and its point-computation datapath. A single start command triggers a sweep of `num_points` angle indices. Indices go to the datapath over a valid/ready request channel. Returned (x, y) points are buffered in a small result FIFO that software drains through the register block. A credit scheme ensures the number of outstanding requests never exceeds free FIFO space, so the response channel needs no backpressure.

## Interface
- `DATA_W`, 16, width of each coordinate (two's complement).
- `IDX_W`, 8, width of point index and `num_points`.
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, ≥2.

Ports:
- `S_AXI_ACLK` in 1: the block's only clock; all logic on its rising edge.
- `S_AXI_ARESETN` in 1: reset, asynchronous and active-low.
- `start` in 1: single-cycle command pulse from CTRL register write.
- `abort` in 1: single-cycle pulse; cancels the running sweep.
- `num_points` in IDX_W: points per sweep; sampled on accepted `start`.
- `dp_req_valid` out 1: request valid to datapath.
- `dp_req_ready` in 1: datapath accepts request.
- `dp_req_idx` out IDX_W: angle index of the current request.
- `dp_rsp_valid` in 1: datapath result valid; no ready, always consumed.
- `dp_rsp_x`, `dp_rsp_y` in DATA_W each: result coordinates.
- `rd_valid` out 1: FIFO non-empty.
- `rd_x`, `rd_y` out DATA_W each: FIFO head.
- `rd_pop` in 1: pops head when `rd_valid`=1.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: sticky; last sweep completed normally. Cleared by accepted `start`.
- `aborted` out 1: sticky; last sweep ended by abort. Cleared by accepted `start`.
- `irq` out 1: one-cycle pulse on completion or abort finish.
- `err_unexpected` out 1: sticky; response seen with zero outstanding. Cleared only by reset.

## Operation
- Counters:
  - `issued` (IDX_W): requests accepted this sweep.
  - `outstanding` (clog2(FIFO_DEPTH)+1): accepted requests not yet answered.
  - `fifo_cnt` (clog2(FIFO_DEPTH)+1): entries held in the result FIFO.
- Credit rule: a new request may be presented only if `outstanding + fifo_cnt < FIFO_DEPTH`. The FIFO therefore cannot overflow.
- FSM states and transitions:
  - IDLE: `start` is accepted here only.
    - Latch `num_points`, clear `issued`, clear `done`/`aborted`.
    - `num_points`=0: go straight to FINISH.
    - Otherwise go to RUN.
  - RUN: present `dp_req_idx`=`issued` whenever credit allows.
    - Each accepted handshake increments `issued`; the next index follows.
    - When `issued` reaches `num_points` on a handshake, go to DRAIN.
  - DRAIN: no requests. Go to FINISH when `outstanding`=0.
  - FINISH: one cycle. Set `done`, pulse `irq`, return to IDLE.
  - FLUSH: entered on `abort` in RUN or DRAIN.
    - `dp_req_valid` drops next cycle; no new requests.
    - Responses still arriving are discarded, not pushed to the FIFO.
    - When `outstanding`=0: set `aborted`, pulse `irq`, go to IDLE.
- Ignored inputs:
  - `start` while not IDLE.
  - `abort` in IDLE or FINISH.
- `start` and `abort` in the same cycle in IDLE: `start` wins.
- FIFO contents survive abort and FINISH; software drains them with `rd_pop`.
- Response with `outstanding`=0: sets `err_unexpected`; data is discarded.
- Simultaneous push and pop: `fifo_cnt` is unchanged. Pointers wrap modulo FIFO_DEPTH.
- `rd_pop` when empty: no effect.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, FSM = IDLE, FIFO empty.
- Asynchronous reset mid-sweep:
  - Immediately drops `dp_req_valid`, `busy`, `irq`.
  - Empties the FIFO and zeroes all counters.
- `start` at cycle T:
  - `busy`=1 at T+1.
  - First `dp_req_valid`=1 at T+1, or `done`/`irq` at T+2 when `num_points`=0.
- Request handshake rules:
  - `dp_req_valid`/`dp_req_idx` hold stable until `dp_req_ready`. Exception: abort may drop valid.
  - Back-to-back issue of one request per cycle while credit allows.
- Response at cycle T:
  - `rd_valid`=1 at T+1.
  - Credit freed only when the entry is popped.
- Pop at T: the next head appears at T+1.
- Completion latency: last response at T → FINISH at T+1 → `done`=1 and `irq` pulse at T+2.

## Test plan
- Datapath always ready, 3-cycle response latency, `num_points`=3, FIFO popped each cycle:
  - Requests carry idx 0, 1, 2.
  - The FIFO returns three (x, y) pairs in order.
  - `done`=1 and one `irq` pulse.
- `num_points`=10, no pops:
  - Exactly 4 requests are issued, then `dp_req_valid` stays 0.
  - After 2 pops, exactly 2 more requests are issued.
- `dp_req_ready` held low 5 cycles:
  - `dp_req_valid`=1 and `dp_req_idx`=0 remain stable throughout.
  - The handshake completes on the first ready cycle.
- `abort` with 2 requests outstanding:
  - No further requests; both responses are discarded.
  - `aborted`=1, `done`=0, single `irq`.
  - Earlier FIFO entries remain readable.
- `start` with `num_points`=0: `done` and `irq` at T+2, zero requests issued.
- Stray `dp_rsp_valid` in IDLE: `err_unexpected`=1, FIFO stays empty. Reset mid-RUN returns all outputs to 0.
